// File: rtl/rx_word_assembler_if.sv
// Word-stream interface between rx_word_assembler and its consumer (program/data loader).
//
// Signals:
//   word_data  - head-of-FIFO word, little-endian byte order, 0 when no word is stored
//   word_valid - a word is available
//   word_ready - consumer takes the head word when word_valid && word_ready
//
// Modports:
//   master - producer side (rx_word_assembler)
//   slave  - consumer side
interface rx_word_assembler_if #(
    parameter int unsigned WORD_BYTES = 4
);
    logic [8*WORD_BYTES-1:0] word_data;
    logic                    word_valid;
    logic                    word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/rx_word_assembler.sv
// rx_word_assembler
//
// Packs WORD_BYTES consecutive bytes from the RS232 byte receiver into one little-endian word
// (first byte in the LSBs) and queues finished words in a FIFO_DEPTH-entry FIFO that the
// loader drains through a valid/ready handshake.
//
// Optional feature, enabled by defining RX_TIMEOUT_EN:
//   a partial word is discarded (timeout_err pulses for one cycle) when TIMEOUT_TICKS
//   baudTick pulses pass without a new byte. Without the macro a partial word waits forever
//   and timeout_err is tied low.
//
// Ports:
//   clk            - system clock, rising edge
//   rst_n          - synchronous active-low reset
//   baudTick       - 8x baud oversampling tick (only used with RX_TIMEOUT_EN)
//   RxD_data_ready - one-cycle strobe, RxD_data holds a valid byte
//   RxD_data       - received byte
//   word_if        - master side of the word stream (word_data, word_valid, word_ready)
//   fifo_count     - number of stored words, 0..FIFO_DEPTH
//   overflow       - sticky, set when a completed word is dropped because the FIFO is full
//   timeout_err    - one-cycle pulse when a partial word is discarded
module rx_word_assembler #(
    parameter int unsigned WORD_BYTES    = 4,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned TIMEOUT_TICKS = 320
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          baudTick,
    input  logic                          RxD_data_ready,
    input  logic [7:0]                    RxD_data,
    rx_word_assembler_if.master           word_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          timeout_err
);

    localparam int unsigned WordW = 8 * WORD_BYTES;
    localparam int unsigned IdxW  = $clog2(WORD_BYTES);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;

    localparam logic [IdxW-1:0]  LastIdx      = IdxW'(WORD_BYTES - 1);
    localparam logic [CntW-1:0]  FullCount    = CntW'(FIFO_DEPTH);
    localparam logic [15:0]      TimeoutLimit = 16'(TIMEOUT_TICKS);

    // ------------------------------------------------------------------------------------------
    // Byte assembly
    // ------------------------------------------------------------------------------------------
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WordW-1:0] asm_q, asm_d;
    logic [WordW-1:0] word_next;   // assembly register with the incoming byte merged in
    logic             expire;      // partial word has timed out this cycle

    always_comb begin
        word_next = asm_q;
        word_next[8*int'(idx_q) +: 8] = RxD_data;
    end

    always_comb begin
        idx_d = idx_q;
        asm_d = asm_q;
        if (RxD_data_ready) begin
            // A byte arriving in the expiry cycle wins over the timeout.
            asm_d = word_next;
            idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
        end else if (expire) begin
            asm_d = '0;
            idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q <= '0;
            asm_q <= '0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
        end
    end

    // ------------------------------------------------------------------------------------------
    // Inter-byte timeout
    // ------------------------------------------------------------------------------------------
`ifdef RX_TIMEOUT_EN
    logic [15:0] tick_cnt_q;
    logic        timeout_err_q;

    assign expire = (idx_q != '0) && (tick_cnt_q == TimeoutLimit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (RxD_data_ready || (idx_q == '0) || expire) begin
                tick_cnt_q <= '0;
            end else if (baudTick) begin
                tick_cnt_q <= tick_cnt_q + 16'd1;
            end
            timeout_err_q <= expire && !RxD_data_ready;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic        unused_baud_tick;
    logic [15:0] unused_timeout_limit;

    assign unused_baud_tick     = baudTick;
    assign unused_timeout_limit = TimeoutLimit;
    assign expire               = 1'b0;
    assign timeout_err          = 1'b0;
`endif

    // ------------------------------------------------------------------------------------------
    // Word FIFO; EMPTY / PARTIAL / FULL are implied by count_q
    // ------------------------------------------------------------------------------------------
    logic [WordW-1:0] mem [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             overflow_q;

    logic fifo_empty, fifo_full;
    logic push_req, push, pop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FullCount);
    assign push_req   = RxD_data_ready && (idx_q == LastIdx);
    assign pop        = !fifo_empty && word_if.word_ready;
    // A pop frees the head slot at the same edge, so a full FIFO still accepts the word.
    assign push       = push_req && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (push_req && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: unused entries are never visible because word_data is gated by
    // the count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= word_next;
        end
    end

    assign word_if.word_data  = fifo_empty ? '0 : mem[rd_ptr_q];
    assign word_if.word_valid = !fifo_empty;
    assign fifo_count         = count_q;
    assign overflow           = overflow_q;

endmodule

// File: tb/tb_rx_word_assembler.sv
module tb_rx_word_assembler;

    localparam int unsigned WB    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TO    = 320;
    localparam int unsigned WW    = 8 * WB;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef RX_TIMEOUT_EN
    localparam bit TimeoutOn = 1'b1;
`else
    localparam bit TimeoutOn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick;
    logic          rxd_ready;
    logic [7:0]    rxd_data;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          timeout_err;

    rx_word_assembler_if #(.WORD_BYTES(WB)) wif ();

    rx_word_assembler #(
        .WORD_BYTES    (WB),
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_TICKS (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .baudTick       (tick),
        .RxD_data_ready (rxd_ready),
        .RxD_data       (rxd_data),
        .word_if        (wif),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: received bytes of the current word, stored words, sticky flag.
    logic [7:0]    m_part [$];
    logic [WW-1:0] m_fifo [$];
    bit            m_ovf;
    bit            m_terr;
    int            m_ticks;

    logic          exp_valid;
    logic [WW-1:0] exp_data;
    logic [CW-1:0] exp_count;
    logic          exp_ovf;
    logic          exp_terr;

    // Apply the current inputs for one clock edge to both model and DUT, then settle.
    task automatic step();
        bit            pop;
        bit            do_push;
        logic [WW-1:0] w;
        m_terr  = 1'b0;
        do_push = 1'b0;
        w       = '0;
        if (!rst_n) begin
            m_part.delete();
            m_fifo.delete();
            m_ovf   = 1'b0;
            m_ticks = 0;
        end else begin
            pop = (m_fifo.size() > 0) && wif.word_ready;
            if (rxd_ready) begin
                m_part.push_back(rxd_data);
                m_ticks = 0;
                if (m_part.size() == WB) begin
                    for (int i = 0; i < WB; i++) w = w | (WW'(m_part[i]) << (8 * i));
                    m_part.delete();
                    if (m_fifo.size() < DEPTH || pop) do_push = 1'b1;
                    else m_ovf = 1'b1;
                end
            end else if (m_part.size() == 0) begin
                m_ticks = 0;
            end else if (TimeoutOn && m_ticks == TO) begin
                m_part.delete();
                m_ticks = 0;
                m_terr  = 1'b1;
            end else if (tick) begin
                m_ticks++;
            end
            if (pop) void'(m_fifo.pop_front());
            if (do_push) m_fifo.push_back(w);
        end
        @(posedge clk);
        #1;
        exp_valid = (m_fifo.size() > 0);
        exp_data  = exp_valid ? m_fifo[0] : '0;
        exp_count = CW'(m_fifo.size());
        exp_ovf   = m_ovf;
        exp_terr  = m_terr;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rxd_ready = 1'b1;
        rxd_data  = b;
        step();
        rxd_ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        rxd_ready = 1'b0;
        tick      = 1'b0;
        wif.word_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (wif.word_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got=%b want=0", wif.word_valid);
        end
        checks++;
        if (wif.word_data !== '0) begin
            errors++; $display("FAIL reset_data got=%h want=0", wif.word_data);
        end
        checks++;
        if (fifo_count !== '0) begin
            errors++; $display("FAIL reset_count got=%0d want=0", fifo_count);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL reset_overflow got=%b want=0", overflow);
        end
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL reset_timeout got=%b want=0", timeout_err);
        end
    endtask

    task automatic test_single_word();
        apply_reset();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        checks++;
        if (wif.word_valid !== 1'b0) begin
            errors++; $display("FAIL single_early_valid got=%b want=0", wif.word_valid);
        end
        send_byte(8'h44);
        checks++;
        if (wif.word_valid !== 1'b1 || wif.word_data !== 32'h44332211 || fifo_count !== 3'd1)
        begin
            errors++;
            $display("FAIL single_word valid=%b data=%h count=%0d want 1/44332211/1",
                     wif.word_valid, wif.word_data, fifo_count);
        end
        // Pop it and make sure the FIFO is empty again.
        wif.word_ready = 1'b1;
        step();
        wif.word_ready = 1'b0;
        checks++;
        if (wif.word_valid !== 1'b0 || fifo_count !== 3'd0 || wif.word_data !== '0) begin
            errors++;
            $display("FAIL single_drain valid=%b count=%0d data=%h want 0/0/0",
                     wif.word_valid, fifo_count, wif.word_data);
        end
    endtask

    task automatic test_overflow();
        logic [WW-1:0] words [5];
        logic [7:0]    b;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            words[k] = '0;
            for (int i = 0; i < WB; i++) begin
                b = 8'($urandom);
                words[k][8*i +: 8] = b;
                send_byte(b);
                step();
            end
        end
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_state count=%0d ovf=%b want 4/1", fifo_count, overflow);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wif.word_valid !== 1'b1 || wif.word_data !== words[k]) begin
                errors++;
                $display("FAIL overflow_drain%0d valid=%b data=%h want 1/%h",
                         k, wif.word_valid, wif.word_data, words[k]);
            end
            wif.word_ready = 1'b1;
            step();
        end
        wif.word_ready = 1'b0;
        checks++;
        if (wif.word_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_lost valid=%b count=%0d ovf=%b want 0/0/1",
                     wif.word_valid, fifo_count, overflow);
        end
    endtask

    task automatic test_push_pop_full();
        logic [WW-1:0] words [5];
        logic [7:0]    b;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            words[k] = '0;
            for (int i = 0; i < WB; i++) begin
                b = 8'($urandom);
                words[k][8*i +: 8] = b;
                if (k == 4 && i == WB - 1) wif.word_ready = 1'b1;
                send_byte(b);
                wif.word_ready = 1'b0;
            end
        end
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_pushpop count=%0d ovf=%b want 4/0", fifo_count, overflow);
        end
        for (int k = 1; k < 5; k++) begin
            checks++;
            if (wif.word_data !== words[k]) begin
                errors++;
                $display("FAIL full_pushpop_drain%0d data=%h want %h",
                         k, wif.word_data, words[k]);
            end
            wif.word_ready = 1'b1;
            step();
        end
        wif.word_ready = 1'b0;
        checks++;
        if (wif.word_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_pushpop_end valid=%b ovf=%b want 0/0", wif.word_valid, overflow);
        end
    endtask

    task automatic test_reset_mid_word();
        apply_reset();
        send_byte(8'h01);
        send_byte(8'h02);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        checks++;
        if (wif.word_valid !== 1'b1 || wif.word_data !== 32'hDDCCBBAA || fifo_count !== 3'd1)
        begin
            errors++;
            $display("FAIL reset_mid_word valid=%b data=%h count=%0d want 1/ddccbbaa/1",
                     wif.word_valid, wif.word_data, fifo_count);
        end
    endtask

    task automatic test_timeout();
        int            pulses = 0;
        logic [WW-1:0] want;
        want = TimeoutOn ? 32'h04030201 : 32'h0302015A;
        apply_reset();
        send_byte(8'h5A);
        tick = 1'b1;
        for (int i = 0; i < TO + 4; i++) begin
            if (i == TO) tick = 1'b0;
            step();
            if (timeout_err === 1'b1) pulses++;
            checks++;
            if (timeout_err !== exp_terr) begin
                errors++;
                $display("FAIL timeout_pulse cyc=%0d got=%b want=%b", i, timeout_err, exp_terr);
            end
        end
        checks++;
        if (pulses != (TimeoutOn ? 1 : 0)) begin
            errors++;
            $display("FAIL timeout_count got=%0d want=%0d", pulses, TimeoutOn ? 1 : 0);
        end
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        checks++;
        if (wif.word_valid !== 1'b1 || wif.word_data !== want || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL timeout_next_word valid=%b data=%h count=%0d want 1/%h/1",
                     wif.word_valid, wif.word_data, fifo_count, want);
        end
    endtask

    task automatic test_expiry_race();
        apply_reset();
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        tick = 1'b1;
        for (int i = 0; i < TO; i++) step();
        tick = 1'b0;
        // This cycle is the one in which the counter sits at its limit.
        send_byte(8'h40);
        checks++;
        if (timeout_err !== 1'b0 || wif.word_valid !== 1'b1 || wif.word_data !== 32'h40302010
            || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL expiry_race terr=%b valid=%b data=%h count=%0d want 0/1/40302010/1",
                     timeout_err, wif.word_valid, wif.word_data, fifo_count);
        end
        step();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL expiry_race_late terr=%b want 0", timeout_err);
        end
    endtask

    task automatic test_random();
        int rdy_bias;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            rdy_bias  = (c < 1000) ? 1 : ((c < 2000) ? 3 : 4);
            rst_n     = ($urandom_range(0, 499) != 0);
            rxd_ready = ($urandom_range(0, 1) == 1);
            rxd_data  = 8'($urandom);
            tick      = ($urandom_range(0, 7) == 0);
            wif.word_ready = (int'($urandom_range(0, 3)) < rdy_bias);
            step();
            checks++;
            if (wif.word_valid !== exp_valid || wif.word_data !== exp_data
                || fifo_count !== exp_count || overflow !== exp_ovf
                || timeout_err !== exp_terr) begin
                errors++;
                $display("FAIL random cyc=%0d valid=%b/%b data=%h/%h count=%0d/%0d ovf=%b/%b terr=%b/%b",
                         c, wif.word_valid, exp_valid, wif.word_data, exp_data,
                         fifo_count, exp_count, overflow, exp_ovf, timeout_err, exp_terr);
            end
        end
        rst_n          = 1'b1;
        rxd_ready      = 1'b0;
        tick           = 1'b0;
        wif.word_ready = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        tick           = 1'b0;
        rxd_ready      = 1'b0;
        rxd_data       = '0;
        wif.word_ready = 1'b0;
        m_ovf          = 1'b0;
        m_ticks        = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_word();
        test_overflow();
        test_push_pop_full();
        test_reset_mid_word();
        test_timeout();
        test_expiry_race();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_word_assembler.md
Name: rx_word_assembler

Overview:
- Sits directly downstream of the RS232 byte receiver.
- Consumes the receiver's one-cycle RxD_data_ready strobes and RxD_data bytes, and packs WORD_BYTES consecutive bytes into one little-endian word.
- Queues assembled words in a small FIFO, which the processor's program/data loader drains through a valid/ready handshake.
- Reports FIFO overflow and, optionally, inter-byte timeout of a partial word.

Parameters:
WORD_BYTES, 4, bytes per assembled word (2..4); output word width is 8*WORD_BYTES.
FIFO_DEPTH, 4, word FIFO entries; power of 2, minimum 2.
TIMEOUT_TICKS, 320, baudTick pulses allowed between bytes of one partial word (only used with RX_TIMEOUT_EN); 16-bit counter.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
baudTick  input  1  oversampling tick (8x baud), the same strobe that drives the receiver.
RxD_data_ready  input  1  one-cycle strobe: RxD_data holds a valid byte.
RxD_data  input  8  received byte.
word_data  output  8*WORD_BYTES  FIFO head word; reads 0 when FIFO empty.
word_valid  output  1  FIFO non-empty.
word_ready  input  1  consumer accepts head word when word_valid and word_ready are both high.
fifo_count  output  clog2(FIFO_DEPTH)+1  number of stored words.
overflow  output  1  sticky; set when a completed word is dropped.
timeout_err  output  1  one-cycle pulse when a partial word is discarded.

Behaviour:
- Reset (rst_n low at a clk edge):
  - Clears byte index, shift/assembly register, FIFO pointers, fifo_count, overflow and timeout counter.
  - Outputs after reset: word_valid=0, word_data=0, fifo_count=0, overflow=0, timeout_err=0.
  - Reset mid-word discards the partial word silently; reset with a non-empty FIFO discards all stored words.
- Byte packing:
  - On RxD_data_ready, the byte is stored at bits [8*idx+7 : 8*idx], where idx is the current byte index.
  - idx increments and wraps from WORD_BYTES-1 to 0. The first received byte lands in the LSBs.
  - RxD_data is sampled only on RxD_data_ready; no other qualification.
- Push:
  - Occurs in the cycle the final byte strobe is seen; the word is written into the FIFO at that edge.
  - Latency: word_valid rises the cycle after that strobe cycle (no combinational fall-through from RxD_data).
- FIFO state machine:
  - Implicit states EMPTY / PARTIAL / FULL, derived from fifo_count.
  - Pop when word_valid && word_ready; read pointer advances and the next head word is visible the following cycle.
  - Push and pop in the same cycle, with FIFO non-empty: both occur and fifo_count is unchanged. This holds when FULL as well (push accepted).
  - Push when FULL with no pop: the word is dropped, overflow sets and stays set until reset. idx still wraps to 0 and the FIFO contents are untouched.
  - word_ready while EMPTY: no effect; the pointer does not move.
  - Pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
- The byte index is independent of FIFO state; bytes keep being assembled while FULL.

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- Defined:
  - While idx != 0, a 16-bit counter increments on each baudTick and clears on every RxD_data_ready.
  - When it reaches TIMEOUT_TICKS: the partial word is discarded, idx returns to 0, the counter clears, and timeout_err pulses high for exactly one cycle.
  - If RxD_data_ready coincides with the expiry cycle, the byte wins: it is appended normally, the counter clears and no timeout_err is raised.
  - The counter is held at 0 while idx == 0.
- Undefined:
  - No counter is built and timeout_err is tied 0.
  - A partial word waits indefinitely for its remaining bytes.

Test Plan:
- After reset, strobe bytes 0x11,0x22,0x33,0x44 -> one cycle after the 4th strobe: word_valid=1, word_data=0x44332211, fifo_count=1.
- Hold word_ready=0 and send 5 full words (20 bytes) with FIFO_DEPTH=4 -> fifo_count=4, overflow=1 after the 20th byte; draining yields words 1-4 in order, and word 5 is lost.
- FIFO full, with the 4th byte of a new word strobed in the same cycle as a pop -> fifo_count stays 4, overflow stays 0, new word is the last one drained.
- Assert rst_n=0 for one cycle after 2 bytes of a word, then send 0xAA,0xBB,0xCC,0xDD -> word_data=0xDDCCBBAA; no stale bytes appear.
- RX_TIMEOUT_EN, TIMEOUT_TICKS=320: send 1 byte, then 320 baudTicks with no strobe -> timeout_err single-cycle pulse; the next 4 bytes form a clean word.
- RX_TIMEOUT_EN: send 3 bytes, then strobe the 4th exactly in the expiry cycle -> word pushed, timeout_err=0.
